// File: rtl/riscv_i32_trace_pack.sv
// Retirement-trace compressor: folds straight-line execution into counts and
// queues SYNC/BRANCH/SEQ packets into a word FIFO drained over valid/ack.
module riscv_i32_trace_pack #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned COUNT_MAX   = 65535,
    parameter int unsigned SYNC_PERIOD = 256
) (
    input  logic                          clk,
    input  logic                          clk__enable,
    input  logic                          reset_n,
    input  logic                          trace_enable,
    input  logic                          instr_valid,
    input  logic [31:0]                   pc,
    input  logic                          branch_taken,
    input  logic [31:0]                   branch_target,
    output logic                          trace_valid,
    output logic [31:0]                   trace_data,
    input  logic                          trace_ack,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    localparam logic [3:0] TYPE_NONE        = 4'd0;
    localparam logic [3:0] TYPE_SYNC        = 4'd1;
    localparam logic [3:0] TYPE_BRANCH      = 4'd2;
    localparam logic [3:0] TYPE_SEQ         = 4'd3;
    localparam logic [3:0] TYPE_SYNC_BRANCH = 4'd4;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;

    logic [15:0]   seq_count;
    logic [31:0]   sync_ctr;
    logic          sync_pending;
    logic          enable_d;

    logic          accept;
    logic          eff_pending;
    logic [3:0]    pkt_type;
    logic [1:0]    pkt_len;
    logic [15:0]   pkt_count;
    logic [31:0]   pkt_word [3];
    logic [LW-1:0] free;
    logic          push;
    logic          drop;
    logic          pop;

    logic [15:0]   seq_count_next;
    logic [31:0]   sync_ctr_next;
    logic          sync_pending_next;
    logic          overflow_next;

    assign trace_valid = (level != '0);
    assign trace_data  = trace_valid ? mem[rd_ptr] : 32'd0;
    assign fifo_level  = level;
    assign pop         = trace_valid & trace_ack;

    // Packet selection; a rising trace_enable behaves as a pending sync.
    always_comb begin
        accept      = instr_valid & trace_enable;
        eff_pending = sync_pending | (trace_enable & ~enable_d);
        pkt_type    = TYPE_NONE;
        pkt_len     = 2'd0;
        pkt_count   = 16'd0;
        pkt_word[1] = pc;
        pkt_word[2] = branch_target;
        if (eff_pending) begin
            pkt_count = seq_count;
            if (branch_taken) begin
                pkt_type = TYPE_SYNC_BRANCH;
                pkt_len  = 2'd3;
            end else begin
                pkt_type = TYPE_SYNC;
                pkt_len  = 2'd2;
            end
        end else if (branch_taken) begin
            pkt_type    = TYPE_BRANCH;
            pkt_len     = 2'd2;
            pkt_count   = seq_count + 16'd1;
            pkt_word[1] = branch_target;
        end else if ({16'd0, seq_count} + 32'd1 == COUNT_MAX) begin
            pkt_type  = TYPE_SEQ;
            pkt_len   = 2'd1;
            pkt_count = 16'(COUNT_MAX);
        end
        pkt_word[0] = {pkt_type, overflow, 11'd0, pkt_count};

        // Free space is measured before this cycle's pop on purpose.
        free = LW'(FIFO_DEPTH) - level;
        push = accept && (pkt_len != 2'd0) && (free >= LW'(pkt_len));
        drop = accept && (pkt_len != 2'd0) && (free <  LW'(pkt_len));
    end

    always_comb begin
        seq_count_next    = seq_count;
        sync_ctr_next     = sync_ctr;
        sync_pending_next = eff_pending;
        overflow_next     = overflow;
        if (drop) begin
            seq_count_next    = 16'd0;
            overflow_next     = 1'b1;
            sync_pending_next = 1'b1;
        end else if (accept) begin
            case (pkt_type)
                TYPE_SYNC, TYPE_SYNC_BRANCH: begin
                    // A plain SYNC leaves the current instruction for the next count.
                    seq_count_next    = (pkt_type == TYPE_SYNC) ? 16'd1 : 16'd0;
                    sync_pending_next = 1'b0;
                    sync_ctr_next     = 32'd0;
                    overflow_next     = 1'b0;
                end
                TYPE_BRANCH, TYPE_SEQ: begin
                    seq_count_next = 16'd0;
                    if (sync_ctr + 32'd1 == SYNC_PERIOD) begin
                        sync_pending_next = 1'b1;
                        sync_ctr_next     = 32'd0;
                    end else begin
                        sync_ctr_next = sync_ctr + 32'd1;
                    end
                end
                default: seq_count_next = seq_count + 16'd1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clk__enable) begin
            if (!reset_n) begin
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                level        <= '0;
                seq_count    <= 16'd0;
                sync_ctr     <= 32'd0;
                sync_pending <= 1'b1;
                overflow     <= 1'b0;
                enable_d     <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(pkt_len);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                level        <= level + (push ? LW'(pkt_len) : LW'(0)) - (pop ? LW'(1) : LW'(0));
                seq_count    <= seq_count_next;
                sync_ctr     <= sync_ctr_next;
                sync_pending <= sync_pending_next;
                overflow     <= overflow_next;
                enable_d     <= trace_enable;
            end
        end
    end

    // All words of a packet land in one cycle; storage itself is not reset.
    always_ff @(posedge clk) begin
        if (clk__enable && reset_n && push) begin
            for (int i = 0; i < 3; i++) begin
                if (i < int'(pkt_len)) begin
                    mem[wr_ptr + AW'(i)] <= pkt_word[i];
                end
            end
        end
    end
endmodule
